// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and size codes for the SRAM port arbiter.
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {GNT_INST, GNT_DATA} gnt_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/sram_arb_streak.sv
// sram_arb_streak: saturating count of data grants taken while a fetch waits.
module sram_arb_streak #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic limit
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt;
  assign limit = cnt == W'(MAX);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !limit) cnt <= cnt + 1'b1;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between fetch and data requesters,
// one transaction in flight, data first unless fetch has waited MAX_DATA_STREAK grants.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t state;
  gnt_t   gnt;
  logic   live, limit, grant_inst, grant_data, resp_phase;
  // resetn gates the combinational grant so no addr_ok escapes while reset is held
  assign live         = state == IDLE && resetn;
  assign grant_data   = live && data_req && !(inst_req && limit);
  assign grant_inst   = live && inst_req && !grant_data;
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign resp_phase   = state == RESP || (state == REQ && mem_addr_ok);
  assign inst_data_ok = mem_data_ok && resp_phase && gnt == GNT_INST;
  assign data_data_ok = mem_data_ok && resp_phase && gnt == GNT_DATA;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign mem_req      = state == REQ;
  assign busy         = state != IDLE;
  sram_arb_streak #(.MAX(MAX_DATA_STREAK)) u_streak (
    .clk   (clk),
    .resetn(resetn),
    .inc   (grant_data && inst_req),
    .clr   (grant_inst || (grant_data && !inst_req)),
    .limit (limit)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= GNT_INST;
      mem_wr    <= 1'b0;
      mem_size  <= SZ_BYTE;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (grant_data) begin
            state     <= REQ;
            gnt       <= GNT_DATA;
            mem_wr    <= data_wr;
            mem_size  <= data_size;
            mem_wstrb <= data_wstrb;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
          end else if (grant_inst) begin
            state     <= REQ;
            gnt       <= GNT_INST;
            mem_wr    <= 1'b0;
            mem_size  <= SZ_WORD;
            mem_wstrb <= '0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
          end
        REQ:     if (mem_addr_ok) state <= mem_data_ok ? IDLE : RESP;
        RESP:    if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one SRAM-like memory port between the CPU's instruction-fetch requester and data-access requester, one outstanding transaction at a time. It sits between the `mips` core and the physical memory/MMU path. It accepts a request from one side and replays it to memory, then routes the response back to the originator. Data accesses have priority, bounded by a fairness counter so fetch cannot starve.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_DATA_STREAK`, default 4: maximum consecutive data grants allowed while an inst request waits.

- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous, active-low.
- `inst_req` input 1: fetch request; held stable until `inst_addr_ok`.
- `inst_addr` input ADDR_W: fetch address.
- `inst_addr_ok` output 1: request captured (1-cycle pulse).
- `inst_data_ok` output 1: read data valid (1-cycle pulse).
- `inst_rdata` output DATA_W: fetch data.
- `data_req` input 1: data request; held stable until `data_addr_ok`.
- `data_wr` input 1: 1 = write.
- `data_size` input 2: access size, 0 = byte, 1 = half, 2 = word.
- `data_wstrb` input 4: byte write enables.
- `data_addr` input ADDR_W: data address.
- `data_wdata` input DATA_W: write data.
- `data_addr_ok` output 1: request captured (1-cycle pulse).
- `data_data_ok` output 1: read data valid or write complete (1-cycle pulse).
- `data_rdata` output DATA_W: load data.
- `mem_req`, `mem_wr`, `mem_size`[2], `mem_wstrb`[4], `mem_addr`[ADDR_W], `mem_wdata`[DATA_W` outputs: shared port request fields.
- `mem_addr_ok`, `mem_data_ok` input 1 each; `mem_rdata` input DATA_W: shared port responses.
- `busy` output 1: state != IDLE.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: `mem_req` = 1 with latched fields.
  - RESP: waiting for `mem_data_ok`.
- Arbitration in IDLE:
  - Grant data if `data_req`, unless `inst_req` && `streak` == MAX_DATA_STREAK; otherwise grant inst if `inst_req`.
  - On grant, pulse the winner's `*_addr_ok` combinationally in the same cycle.
  - Latch the winner's fields and the grant ID, then go to REQ.
- Latched inst fields: `wr` = 0, `size` = 2, `wstrb` = 0, `wdata` = 0.
- `streak` counter, width clog2(MAX_DATA_STREAK+1):
  - On a data grant with `inst_req` = 1: increment, saturating.
  - On a data grant with `inst_req` = 0, or on an inst grant: clear to 0.
- REQ transitions:
  - `mem_addr_ok` = 1 → RESP.
  - `mem_addr_ok` && `mem_data_ok` in the same cycle → response delivered, go directly to IDLE.
- RESP: on `mem_data_ok`, go to IDLE.
- Response delivery:
  - `*_data_ok` = `mem_data_ok` qualified by the grant ID and state (RESP, or REQ && `mem_addr_ok`).
  - `*_rdata` = `mem_rdata`, combinational pass-through.
  - The non-granted side's `data_ok` stays 0.
- `mem_data_ok` in IDLE, or in REQ without `mem_addr_ok`, is ignored; this covers stale responses after reset.
- `mem_*` fields are held constant throughout REQ; in IDLE/RESP, `mem_req` = 0 and the fields keep their last latched values.

## Timing
- Reset values (async, `resetn` low):
  - State = IDLE, `streak` = 0, grant = inst.
  - Latched fields = 0, so `mem_req` = 0 and `busy` = 0.
  - All `*_addr_ok` / `*_data_ok` = 0.
  - An assertion mid-transaction aborts it; no response is delivered.
- Zero-wait memory (`addr_ok` in the first REQ cycle, `data_ok` on the next cycle):
  - `req` at cycle 0 → `addr_ok` cycle 0, `mem_req` cycle 1, `data_ok` cycle 2, next grant possible at cycle 3.
- Both requesters asserting in IDLE: exactly one `addr_ok` pulse; the loser keeps `req` high and is granted on a later IDLE cycle.
- Each `*_addr_ok` / `*_data_ok` is at most 1 cycle wide per transaction.

## Structure
- Shared package `sram_arb_pkg`:
  - State enum {IDLE, REQ, RESP}.
  - Grant enum {GNT_INST, GNT_DATA}.
  - Size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
- One sub-module, `sram_arb_streak`: saturating fairness counter.
  - Inputs: `clk`, `resetn`, `inc`, `clr`.
  - Output: `limit`.
- FSM and field latches live in the top of this block.

## Test plan
- Single inst fetch, addr 0xBFC00000, zero-wait memory, rdata 0x3C080001 → `inst_addr_ok` cycle 0, `mem_addr` = 0xBFC00000 cycle 1, `inst_data_ok` with 0x3C080001 cycle 2, `data_data_ok` = 0 throughout.
- Simultaneous `inst_req` and `data_req` (data write, addr 0x80001000, wstrb 0xF, wdata 0xDEADBEEF) → data granted first with `mem_wr` = 1 and `mem_wstrb` = 0xF; inst granted in the next IDLE cycle; each side sees exactly one `data_ok`.
- `data_req` held continuously with `inst_req` held, MAX_DATA_STREAK = 4 → grant order D,D,D,D,I,D,...
- Memory stalls `mem_addr_ok` for 3 cycles then `mem_data_ok` 2 cycles later → `mem_req` high 4 cycles with fields stable, `busy` high, single `data_ok`.
- `resetn` pulsed low in RESP, then `mem_data_ok` = 1 arrives after release → no `*_data_ok`, state IDLE, `mem_req` = 0.
- `mem_addr_ok` and `mem_data_ok` both high in the first REQ cycle → `data_ok` same cycle, IDLE next cycle.
